// File: rtl/conv_window_addr_gen_if.sv
// Beat bus between the convolution window address generator and its consumer.
// The generator drives the beat fields and status. The consumer drives start and out_ready.
interface conv_window_addr_gen_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                          start;
    logic                          busy;
    logic                          out_valid;
    logic                          out_ready;
    logic [ADDR_WIDTH-1:0]         out_row;
    logic [ADDR_WIDTH-1:0]         out_col;
    logic [ADDR_WIDTH-1:0]         k_row;
    logic [ADDR_WIDTH-1:0]         k_col;
    logic signed [ADDR_WIDTH:0]    in_row;
    logic signed [ADDR_WIDTH:0]    in_col;
    logic [2*ADDR_WIDTH-1:0]       in_addr;
    logic                          pad;
    logic                          last_tap;
    logic                          last;
    logic                          done;

    modport master (
        input  start, out_ready,
        output busy, out_valid, out_row, out_col, k_row, k_col,
               in_row, in_col, in_addr, pad, last_tap, last, done
    );

    modport slave (
        output start, out_ready,
        input  busy, out_valid, out_row, out_col, k_row, k_col,
               in_row, in_col, in_addr, pad, last_tap, last, done
    );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Convolution window address generator.
// Sweeps every (output pixel, kernel tap) pair of one frame, one beat per accepted handshake.
// Each beat carries the input coordinate it reads. Coordinates in the zero-pad border are
// flagged with pad and given address 0.
module conv_window_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int IN_H       = 4,
    parameter int IN_W       = 4,
    parameter int K_H        = 3,
    parameter int K_W        = 3,
    parameter int STRIDE     = 1,
    parameter int PADDING    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv_window_addr_gen_if.master bus
);
    localparam int OUT_H = (IN_H + 2*PADDING - K_H) / STRIDE + 1;
    localparam int OUT_W = (IN_W + 2*PADDING - K_W) / STRIDE + 1;

    localparam logic [ADDR_WIDTH-1:0] K_H_MAX   = ADDR_WIDTH'(K_H - 1);
    localparam logic [ADDR_WIDTH-1:0] K_W_MAX   = ADDR_WIDTH'(K_W - 1);
    localparam logic [ADDR_WIDTH-1:0] OUT_H_MAX = ADDR_WIDTH'(OUT_H - 1);
    localparam logic [ADDR_WIDTH-1:0] OUT_W_MAX = ADDR_WIDTH'(OUT_W - 1);

    localparam logic signed [ADDR_WIDTH:0] STRIDE_S = (ADDR_WIDTH+1)'(STRIDE);
    localparam logic signed [ADDR_WIDTH:0] PAD_S    = (ADDR_WIDTH+1)'(PADDING);
    localparam logic signed [ADDR_WIDTH:0] IN_H_S   = (ADDR_WIDTH+1)'(IN_H);
    localparam logic signed [ADDR_WIDTH:0] IN_W_S   = (ADDR_WIDTH+1)'(IN_W);
    localparam logic [2*ADDR_WIDTH-1:0]    IN_W_L   = (2*ADDR_WIDTH)'(IN_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] out_row_q, out_col_q, k_row_q, k_col_q;
    logic                  clear, advance;
    logic                  last_tap, last;
    logic signed [ADDR_WIDTH:0] in_row, in_col;
    logic                  pad;

    // State register. Reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state, plus the counter clear/advance strobes derived from the handshake.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (bus.out_ready) begin
                    advance = 1'b1;
                    if (last) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Nested loop counters: k_col innermost, then k_row, out_col, out_row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row_q <= '0;
            out_col_q <= '0;
            k_row_q   <= '0;
            k_col_q   <= '0;
        end else if (clear) begin
            out_row_q <= '0;
            out_col_q <= '0;
            k_row_q   <= '0;
            k_col_q   <= '0;
        end else if (advance) begin
            if (k_col_q == K_W_MAX) begin
                k_col_q <= '0;
                if (k_row_q == K_H_MAX) begin
                    k_row_q <= '0;
                    if (out_col_q == OUT_W_MAX) begin
                        out_col_q <= '0;
                        out_row_q <= (out_row_q == OUT_H_MAX) ? '0 : out_row_q + ADDR_WIDTH'(1);
                    end else begin
                        out_col_q <= out_col_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    k_row_q <= k_row_q + ADDR_WIDTH'(1);
                end
            end else begin
                k_col_q <= k_col_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign last_tap = (k_row_q == K_H_MAX) && (k_col_q == K_W_MAX);
    assign last     = last_tap && (out_row_q == OUT_H_MAX) && (out_col_q == OUT_W_MAX);

    assign in_row = $signed({1'b0, out_row_q}) * STRIDE_S + $signed({1'b0, k_row_q}) - PAD_S;
    assign in_col = $signed({1'b0, out_col_q}) * STRIDE_S + $signed({1'b0, k_col_q}) - PAD_S;
    assign pad    = (in_row < 0) || (in_row >= IN_H_S) || (in_col < 0) || (in_col >= IN_W_S);

    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.k_row     = k_row_q;
    assign bus.k_col     = k_col_q;
    assign bus.in_row    = in_row;
    assign bus.in_col    = in_col;
    assign bus.pad       = pad;
    assign bus.last_tap  = last_tap;
    assign bus.last      = last;
    assign bus.in_addr   = pad ? '0
                         : (2*ADDR_WIDTH)'(in_row[ADDR_WIDTH-1:0]) * IN_W_L
                           + (2*ADDR_WIDTH)'(in_col[ADDR_WIDTH-1:0]);
endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Self-checking bench for conv_window_addr_gen.
// Instance A uses the default geometry (4x4, K3, S1, P1). Instance B uses 5x5, K3, S2, P0.
// Every beat is compared against a reference model that decodes the beat index arithmetically.
module tb_conv_window_addr_gen;
    typedef struct {
        int orow, ocol, krow, kcol, irow, icol, addr;
        int pad, last_tap, last;
    } beat_t;

    typedef struct {
        int    cfg;
        int    beat;
        beat_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   sel = 0;
    logic start_drv = 1'b0;
    logic ready_drv = 1'b0;

    int checks = 0;
    int fails  = 0;

    beat_t cap[2][144];
    vec_t  vecs[$];

    conv_window_addr_gen_if #(.ADDR_WIDTH(8)) bus_a ();
    conv_window_addr_gen_if #(.ADDR_WIDTH(8)) bus_b ();

    conv_window_addr_gen #(
        .ADDR_WIDTH(8), .IN_H(4), .IN_W(4), .K_H(3), .K_W(3), .STRIDE(1), .PADDING(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    conv_window_addr_gen #(
        .ADDR_WIDTH(8), .IN_H(5), .IN_W(5), .K_H(3), .K_W(3), .STRIDE(2), .PADDING(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Route the stimulus to the selected instance only; the other one sees no start and no ready.
    always_comb begin
        bus_a.start     = (sel == 0) && start_drv;
        bus_a.out_ready = (sel == 0) && ready_drv;
        bus_b.start     = (sel == 1) && start_drv;
        bus_b.out_ready = (sel == 1) && ready_drv;
    end

    function automatic int obs_valid();
        return (sel == 0) ? int'(bus_a.out_valid) : int'(bus_b.out_valid);
    endfunction

    function automatic int obs_busy();
        return (sel == 0) ? int'(bus_a.busy) : int'(bus_b.busy);
    endfunction

    function automatic int obs_done();
        return (sel == 0) ? int'(bus_a.done) : int'(bus_b.done);
    endfunction

    function automatic beat_t obs_beat();
        beat_t b;
        if (sel == 0) begin
            b.orow = int'(bus_a.out_row);  b.ocol = int'(bus_a.out_col);
            b.krow = int'(bus_a.k_row);    b.kcol = int'(bus_a.k_col);
            b.irow = int'(bus_a.in_row);   b.icol = int'(bus_a.in_col);
            b.addr = int'(bus_a.in_addr);  b.pad  = int'(bus_a.pad);
            b.last_tap = int'(bus_a.last_tap); b.last = int'(bus_a.last);
        end else begin
            b.orow = int'(bus_b.out_row);  b.ocol = int'(bus_b.out_col);
            b.krow = int'(bus_b.k_row);    b.kcol = int'(bus_b.k_col);
            b.irow = int'(bus_b.in_row);   b.icol = int'(bus_b.in_col);
            b.addr = int'(bus_b.in_addr);  b.pad  = int'(bus_b.pad);
            b.last_tap = int'(bus_b.last_tap); b.last = int'(bus_b.last);
        end
        return b;
    endfunction

    function automatic void geometry(input int cfg, output int ih, output int iw, output int kh,
                                     output int kw, output int s, output int p);
        if (cfg == 0) begin ih = 4; iw = 4; kh = 3; kw = 3; s = 1; p = 1; end
        else          begin ih = 5; iw = 5; kh = 3; kw = 3; s = 2; p = 0; end
    endfunction

    function automatic int frame_beats(input int cfg);
        int ih, iw, kh, kw, s, p;
        geometry(cfg, ih, iw, kh, kw, s, p);
        return ((ih + 2*p - kh) / s + 1) * ((iw + 2*p - kw) / s + 1) * kh * kw;
    endfunction

    // Reference: decode beat index n of the frame directly into its coordinates.
    function automatic beat_t model_beat(input int cfg, input int n);
        int ih, iw, kh, kw, s, p, ow, pix;
        beat_t b;
        geometry(cfg, ih, iw, kh, kw, s, p);
        ow = (iw + 2*p - kw) / s + 1;
        pix = n / (kh * kw);
        b.kcol = n % kw;
        b.krow = (n / kw) % kh;
        b.ocol = pix % ow;
        b.orow = pix / ow;
        b.irow = b.orow * s + b.krow - p;
        b.icol = b.ocol * s + b.kcol - p;
        b.pad  = (b.irow < 0 || b.irow >= ih || b.icol < 0 || b.icol >= iw) ? 1 : 0;
        b.addr = b.pad ? 0 : b.irow * iw + b.icol;
        b.last_tap = ((n % (kh * kw)) == kh * kw - 1) ? 1 : 0;
        b.last = (n == frame_beats(cfg) - 1) ? 1 : 0;
        return b;
    endfunction

    function automatic vec_t mk(input int cfg, input int beat, input int orow, input int ocol,
                                input int krow, input int kcol, input int irow, input int icol,
                                input int addr, input int pad, input int lt, input int last);
        vec_t v;
        v.cfg = cfg; v.beat = beat;
        v.exp.orow = orow; v.exp.ocol = ocol; v.exp.krow = krow; v.exp.kcol = kcol;
        v.exp.irow = irow; v.exp.icol = icol; v.exp.addr = addr; v.exp.pad = pad;
        v.exp.last_tap = lt; v.exp.last = last;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkBeat(input string tag, input beat_t act, input beat_t exp);
        checkOutput({tag, ".out_row"},  act.orow, exp.orow);
        checkOutput({tag, ".out_col"},  act.ocol, exp.ocol);
        checkOutput({tag, ".k_row"},    act.krow, exp.krow);
        checkOutput({tag, ".k_col"},    act.kcol, exp.kcol);
        checkOutput({tag, ".in_row"},   act.irow, exp.irow);
        checkOutput({tag, ".in_col"},   act.icol, exp.icol);
        checkOutput({tag, ".in_addr"},  act.addr, exp.addr);
        checkOutput({tag, ".pad"},      act.pad, exp.pad);
        checkOutput({tag, ".last_tap"}, act.last_tap, exp.last_tap);
        checkOutput({tag, ".last"},     act.last, exp.last);
    endtask

    // Run one frame on instance cfg. mode 0: always ready, 1: 3-cycle stall at beat 10,
    // 2: random ready. A second start is pulsed at beat restart_at and reset drops at beat reset_at
    // (-1 disables either).
    task automatic applyStimulus(input int cfg, input int mode, input int restart_at, input int reset_at);
        int    total, beat, cycles, stall;
        bit    aborted, ready;
        beat_t b;
        sel = cfg;
        total = frame_beats(cfg);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        checkOutput($sformatf("cfg%0d.start_busy", cfg), obs_busy(), 1);
        beat = 0; cycles = 0; stall = 0; aborted = 1'b0;
        while (beat < total && cycles < 4 * total + 20 && !aborted) begin
            b = obs_beat();
            checkOutput($sformatf("cfg%0d.valid%0d", cfg, beat), obs_valid(), 1);
            checkBeat($sformatf("cfg%0d.beat%0d", cfg, beat), b, model_beat(cfg, beat));
            if (beat == reset_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("midreset_valid", obs_valid(), 0);
                checkOutput("midreset_busy", obs_busy(), 0);
                aborted = 1'b1;
            end else begin
                case (mode)
                    0: ready = 1'b1;
                    1: begin
                        if (beat == 10 && stall < 3) begin
                            ready = 1'b0;
                            stall++;
                        end else begin
                            ready = 1'b1;
                        end
                    end
                    default: ready = ($urandom_range(0, 3) != 0);
                endcase
                ready_drv = ready;
                start_drv = (beat == restart_at);
                if (ready) cap[cfg][beat] = b;
                @(negedge clk);
                cycles++;
                if (ready) beat++;
            end
        end
        start_drv = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checkOutput("postreset_done", obs_done(), 0);
                checkOutput("postreset_valid", obs_valid(), 0);
                checkOutput("postreset_busy", obs_busy(), 0);
            end
        end else begin
            checkOutput($sformatf("cfg%0d.beat_count", cfg), beat, total);
            if (mode == 0) checkOutput($sformatf("cfg%0d.cycles", cfg), cycles, total);
            checkOutput($sformatf("cfg%0d.done_pulse", cfg), obs_done(), 1);
            checkOutput($sformatf("cfg%0d.done_busy", cfg), obs_busy(), 1);
            checkOutput($sformatf("cfg%0d.done_valid", cfg), obs_valid(), 0);
            @(negedge clk);
            checkOutput($sformatf("cfg%0d.idle_busy", cfg), obs_busy(), 0);
            checkOutput($sformatf("cfg%0d.idle_done", cfg), obs_done(), 0);
            checkOutput($sformatf("cfg%0d.idle_valid", cfg), obs_valid(), 0);
        end
        ready_drv = 1'b0;
    endtask

    // Main sequence: reset, table frames, stall/restart/reset corner cases, then the strided instance.
    initial begin
        vecs.push_back(mk(0,   0, 0, 0, 0, 0, -1, -1,  0, 1, 0, 0));
        vecs.push_back(mk(0,   4, 0, 0, 1, 1,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0,   8, 0, 0, 2, 2,  1,  1,  5, 0, 1, 0));
        vecs.push_back(mk(0,   9, 0, 1, 0, 0, -1,  0,  0, 1, 0, 0));
        vecs.push_back(mk(0,  13, 0, 1, 1, 1,  0,  1,  1, 0, 0, 0));
        vecs.push_back(mk(0,  50, 1, 1, 1, 2,  1,  2,  6, 0, 0, 0));
        vecs.push_back(mk(0, 143, 3, 3, 2, 2,  4,  4,  0, 1, 1, 1));
        vecs.push_back(mk(1,   0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(1,  27, 1, 1, 0, 0,  2,  2, 12, 0, 0, 0));
        vecs.push_back(mk(1,  35, 1, 1, 2, 2,  4,  4, 24, 0, 1, 1));

        repeat (2) @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            sel = c;
            #0;
            checkOutput($sformatf("cfg%0d.reset_valid", c), obs_valid(), 0);
            checkOutput($sformatf("cfg%0d.reset_busy", c), obs_busy(), 0);
            checkOutput($sformatf("cfg%0d.reset_done", c), obs_done(), 0);
        end
        sel = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_no_start_busy", obs_busy(), 0);

        applyStimulus(0, 0, -1, -1);
        applyStimulus(0, 1, 20, -1);
        applyStimulus(0, 2, -1, -1);
        applyStimulus(0, 2, -1, 50);
        applyStimulus(0, 2, -1, -1);
        applyStimulus(1, 2, -1, -1);
        applyStimulus(1, 0, -1, -1);

        foreach (vecs[i])
            checkBeat($sformatf("table%0d", i), cap[vecs[i].cfg][vecs[i].beat], vecs[i].exp);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
